// File: rtl/radix_multiplier_pkg.sv
// Shared types, default sizing and parameter-legality helpers for radix_multiplier.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
//
// Contents: state_t FSM encoding, default-size localparams (N_DIGITS, CNT_W)
// and constant functions used by the top to size itself from its parameters.
package radix_multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Default configuration (WIDTH=16, RADIX_BITS=2).
  localparam int WIDTH_DEF      = 16;
  localparam int RADIX_BITS_DEF = 2;
  localparam int N_DIGITS       = WIDTH_DEF / RADIX_BITS_DEF;
  localparam int CNT_W          = $clog2(N_DIGITS + 1);

  // Number of RADIX_BITS-wide digits in a WIDTH-bit multiplier.
  function automatic int n_digits(input int width, input int radix_bits);
    return width / radix_bits;
  endfunction

  // Counter width able to hold 0..n_digits inclusive.
  function automatic int cnt_w(input int width, input int radix_bits);
    return $clog2((width / radix_bits) + 1);
  endfunction

  function automatic bit params_legal(input int width, input int radix_bits);
    return (width >= 4) && ((width % 2) == 0) &&
           ((radix_bits == 1) || (radix_bits == 2) || (radix_bits == 4)) &&
           ((width % radix_bits) == 0);
  endfunction

endpackage

// File: rtl/radix_multiplier_pp_gen.sv
// Combinational partial-product generator: o_pp = i_mag * i_digit.
// Latency: 0 cycles (pure combinational).
// Backpressure: none, no state.
//
// Ports: i_mag   WIDTH-bit unsigned multiplicand magnitude
//        i_digit RADIX_BITS-bit multiplier digit
//        o_pp    WIDTH+RADIX_BITS-bit product (cannot overflow)
module radix_pp_gen #(
  parameter int WIDTH      = 16,
  parameter int RADIX_BITS = 2
) (
  input  logic [WIDTH-1:0]            i_mag,
  input  logic [RADIX_BITS-1:0]       i_digit,
  output logic [WIDTH+RADIX_BITS-1:0] o_pp
);

  // Shift-and-add over the digit bits; at most 4 terms for the legal radices.
  always_comb begin
    o_pp = '0;
    for (int i = 0; i < RADIX_BITS; i++) begin
      if (i_digit[i]) begin
        o_pp = o_pp + ({{RADIX_BITS{1'b0}}, i_mag} << i);
      end
    end
  end

endmodule

// File: rtl/radix_multiplier.sv
// Iterative signed/unsigned multiplier retiring RADIX_BITS multiplier bits per cycle.
// Latency: N+1 cycles from accept to out_valid_o (N = WIDTH/RADIX_BITS); 2..N+1 with early termination.
// Backpressure: result held in OUT until out_ready_i; in_ready_o only in IDLE, no queuing.
//
// Ports: clk_i/rst_ni (async active-low), in_valid_i/in_ready_o/a_i/b_i/signed_i operand side,
//        out_valid_o/out_ready_i/result_o result side, busy_o high outside IDLE.
// Optional: define RADIX_MULTIPLIER_EARLY_TERM_EN to leave RUN once the remaining multiplier is zero.
module radix_multiplier
  import radix_multiplier_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int RADIX_BITS = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  input  logic                 signed_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 busy_o
);

  localparam int NUM_DIGITS = n_digits(WIDTH, RADIX_BITS);
  localparam int CNT_BITS   = cnt_w(WIDTH, RADIX_BITS);
  localparam int SH_W       = $clog2(2 * WIDTH) + 1;

  if (!params_legal(WIDTH, RADIX_BITS)) begin : g_param_err
    $error("radix_multiplier: illegal WIDTH/RADIX_BITS combination");
  end

  state_t r_state, w_state_nxt;

  logic [WIDTH-1:0]            r_a_mag;
  logic [WIDTH-1:0]            r_b_sr;
  logic                        r_neg;
  logic [2*WIDTH-1:0]          r_acc;
  logic [CNT_BITS-1:0]         r_cnt;
  logic [2*WIDTH-1:0]          r_result;

  logic                        w_accept;
  logic                        w_done;
  logic [WIDTH-1:0]            w_a_mag;
  logic [WIDTH-1:0]            w_b_mag;
  logic [WIDTH+RADIX_BITS-1:0] w_pp;
  logic [2*WIDTH-1:0]          w_pp_ext;
  logic [SH_W-1:0]             w_shamt;

  assign w_accept = (r_state == IDLE) && in_valid_i;

  // Unary minus maps -2^(WIDTH-1) onto 2^(WIDTH-1), which is the correct unsigned magnitude.
  assign w_a_mag = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
  assign w_b_mag = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;

  // The cycle after the last accumulation is spent registering the (possibly negated) result.
`ifdef RADIX_MULTIPLIER_EARLY_TERM_EN
  // At least one digit is always consumed so b=0 still takes one RUN cycle before finishing.
  assign w_done = (r_cnt == CNT_BITS'(NUM_DIGITS)) ||
                  ((r_cnt != '0) && (r_b_sr == '0));
`else
  assign w_done = (r_cnt == CNT_BITS'(NUM_DIGITS));
`endif

  radix_pp_gen #(
    .WIDTH      (WIDTH),
    .RADIX_BITS (RADIX_BITS)
  ) u_pp_gen (
    .i_mag   (r_a_mag),
    .i_digit (r_b_sr[RADIX_BITS-1:0]),
    .o_pp    (w_pp)
  );

  assign w_pp_ext = (2*WIDTH)'(w_pp);
  assign w_shamt  = SH_W'(r_cnt) * SH_W'(RADIX_BITS);

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid_i)  w_state_nxt = RUN;
      RUN:     if (w_done)      w_state_nxt = OUT;
      OUT:     if (out_ready_i) w_state_nxt = IDLE;
      default:                  w_state_nxt = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    in_ready_o  = (r_state == IDLE);
    out_valid_o = (r_state == OUT);
    busy_o      = (r_state != IDLE);
  end

  assign result_o = r_result;

  // Datapath: operand capture, digit-serial accumulation, final sign fix-up.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_a_mag  <= '0;
      r_b_sr   <= '0;
      r_neg    <= 1'b0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_a_mag <= w_a_mag;
      r_b_sr  <= w_b_mag;
      r_neg   <= signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      if (w_done) begin
        r_result <= r_neg ? -r_acc : r_acc;
      end else begin
        r_acc  <= r_acc + (w_pp_ext << w_shamt);
        r_b_sr <= r_b_sr >> RADIX_BITS;
        r_cnt  <= r_cnt + CNT_BITS'(1);
      end
    end
  end

endmodule

// File: tb/tb_radix_multiplier.sv
// Self-checking bench for radix_multiplier (WIDTH=8, RADIX_BITS=2) with a result scoreboard.
// Latency: expects N+1 (or 2 for short multipliers when early termination is compiled in).
// Backpressure: exercises held results, ignored operand pulses and random out_ready_i.
module tb_radix_multiplier;

  localparam int W  = 8;
  localparam int RB = 2;
  localparam int N  = W / RB;
`ifdef RADIX_MULTIPLIER_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  localparam int LAT_FULL  = N + 1;
  localparam int LAT_SHORT = EARLY ? 2 : N + 1;

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  logic           in_valid_i = 1'b0;
  logic           in_ready_o;
  logic [W-1:0]   a_i = '0;
  logic [W-1:0]   b_i = '0;
  logic           signed_i = 1'b0;
  logic           out_valid_o;
  logic           out_ready_i = 1'b0;
  logic [2*W-1:0] result_o;
  logic           busy_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [2*W-1:0] sb_q[$];

  always #5 clk_i = ~clk_i;

  radix_multiplier #(.WIDTH(W), .RADIX_BITS(RB)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .a_i         (a_i),
    .b_i         (b_i),
    .signed_i    (signed_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result_o    (result_o),
    .busy_o      (busy_o)
  );

  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic s);
    longint la, lb, p;
    la = s ? longint'($signed(a)) : longint'(a);
    lb = s ? longint'($signed(b)) : longint'(b);
    p  = la * lb;
    return p[2*W-1:0];
  endfunction

  // Drive one operand set at a negedge while in IDLE; expected result enters the scoreboard on accept.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                      input logic [2*W-1:0] exp);
    a_i = a; b_i = b; signed_i = s; in_valid_i = 1'b1;
    @(posedge clk_i);
    sb_q.push_back(exp);
    @(negedge clk_i);
    in_valid_i = 1'b0;
  endtask

  // Count negedges after the accept edge until out_valid_o is seen (bounded).
  task automatic wait_out(output int lat, output bit to);
    lat = 0; to = 1'b0;
    while (!out_valid_o) begin
      if (lat >= 64) begin
        to = 1'b1;
        break;
      end
      @(negedge clk_i);
      lat++;
    end
  endtask

  task automatic test_reset();
    n_cmp++; if (in_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b need 1", in_ready_o); end
    n_cmp++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b need 0", out_valid_o); end
    n_cmp++; if (result_o !== '0) begin n_err++; $display("FAIL reset_result: got %h need 0", result_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b need 0", busy_o); end
  endtask

  task automatic test_directed();
    logic [W-1:0]   ta [4] = '{8'hFF, 8'h80, 8'hFF, 8'h80};
    logic [W-1:0]   tb [4] = '{8'hFF, 8'h80, 8'h01, 8'h7F};
    logic           ts [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [2*W-1:0] te [4] = '{16'hFE01, 16'h4000, 16'hFFFF, 16'hC080};
    logic [2*W-1:0] exp;
    int lat; bit to;
    for (int i = 0; i < 4; i++) begin
      send(ta[i], tb[i], ts[i], te[i]);
      n_cmp++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL dir_busy[%0d]: got %b need 1", i, busy_o); end
      wait_out(lat, to);
      if (to) begin
        n_cmp++; n_err++; $display("FAIL dir_timeout[%0d]: no out_valid within 64 cycles", i);
        continue;
      end
      if (i == 0) begin
        n_cmp++; if (lat != LAT_FULL) begin n_err++; $display("FAIL dir_latency: got %0d need %0d", lat, LAT_FULL); end
      end
      out_ready_i = 1'b1;
      exp = sb_q.pop_front();
      n_cmp++; if (result_o !== exp) begin n_err++; $display("FAIL dir_result[%0d]: got %h need %h", i, result_o, exp); end
      @(posedge clk_i); @(negedge clk_i);
      out_ready_i = 1'b0;
      n_cmp++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
        n_err++; $display("FAIL dir_release[%0d]: got valid=%b ready=%b need 0/1", i, out_valid_o, in_ready_o);
      end
      n_cmp++; if (result_o !== exp) begin n_err++; $display("FAIL dir_hold_after[%0d]: got %h need %h", i, result_o, exp); end
    end
  endtask

  task automatic test_backpressure();
    logic [2*W-1:0] exp;
    int lat; bit to;
    send(8'd3, 8'd7, 1'b0, 16'd21);
    wait_out(lat, to);
    if (to) begin n_cmp++; n_err++; $display("FAIL bp_timeout: no out_valid within 64 cycles"); end
    exp = sb_q.pop_front();
    for (int c = 0; c < 10; c++) begin
      in_valid_i = c[0]; a_i = 8'hAA; b_i = 8'h55;
      @(negedge clk_i);
      n_cmp++; if (out_valid_o !== 1'b1 || result_o !== exp || in_ready_o !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got valid=%b res=%h rdy=%b need 1/%h/0", c, out_valid_o, result_o, in_ready_o, exp);
      end
    end
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i);
    out_ready_i = 1'b0;
    n_cmp++; if (in_ready_o !== 1'b1 || busy_o !== 1'b0 || out_valid_o !== 1'b0) begin
      n_err++; $display("FAIL bp_release: got rdy=%b busy=%b valid=%b need 1/0/0", in_ready_o, busy_o, out_valid_o);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [2*W-1:0] exp;
    int lat; bit to;
    send(8'd5, 8'd9, 1'b0, 16'd45);
    @(negedge clk_i);           // now inside the second RUN cycle
    rst_ni = 1'b0;
    #1;
    n_cmp++; if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || busy_o !== 1'b0 || result_o !== '0) begin
      n_err++; $display("FAIL rst_mid_outputs: got rdy=%b valid=%b busy=%b res=%h need 1/0/0/0",
                        in_ready_o, out_valid_o, busy_o, result_o);
    end
    sb_q.delete();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      n_cmp++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_mid_no_valid[%0d]: got %b need 0", c, out_valid_o); end
    end
    rst_ni = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_i);
      n_cmp++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_mid_stale[%0d]: got %b need 0", c, out_valid_o); end
    end
    send(8'd12, 8'd10, 1'b0, 16'd120);
    wait_out(lat, to);
    if (to) begin
      n_cmp++; n_err++; $display("FAIL rst_after_timeout: no out_valid within 64 cycles");
    end else begin
      out_ready_i = 1'b1;
      exp = sb_q.pop_front();
      n_cmp++; if (result_o !== exp) begin n_err++; $display("FAIL rst_after_result: got %h need %h", result_o, exp); end
      @(posedge clk_i); @(negedge clk_i);
      out_ready_i = 1'b0;
    end
  endtask

  task automatic test_latency();
    logic [W-1:0]   tb [2] = '{8'h00, 8'h03};
    logic [2*W-1:0] exp;
    int lat; bit to;
    for (int i = 0; i < 2; i++) begin
      send(8'h5A, tb[i], 1'b0, ref_prod(8'h5A, tb[i], 1'b0));
      wait_out(lat, to);
      if (to) begin
        n_cmp++; n_err++; $display("FAIL lat_timeout[%0d]: no out_valid within 64 cycles", i);
        continue;
      end
      n_cmp++; if (lat != LAT_SHORT) begin n_err++; $display("FAIL lat_short[%0d]: got %0d need %0d", i, lat, LAT_SHORT); end
      out_ready_i = 1'b1;
      exp = sb_q.pop_front();
      n_cmp++; if (result_o !== exp) begin n_err++; $display("FAIL lat_result[%0d]: got %h need %h", i, result_o, exp); end
      @(posedge clk_i); @(negedge clk_i);
      out_ready_i = 1'b0;
    end
  endtask

  task automatic test_random();
    logic [W-1:0]   a, b;
    logic           s;
    logic [2*W-1:0] exp;
    bit done;
    for (int t = 0; t < 1000; t++) begin
      a = W'($urandom()); b = W'($urandom()); s = 1'($urandom_range(0, 1));
      if (t < 8) begin a = {1'b1, {(W-1){1'b0}}}; b = W'(t * 37); end
      send(a, b, s, ref_prod(a, b, s));
      done = 1'b0;
      for (int c = 0; c < 200 && !done; c++) begin
        if (out_valid_o) begin
          out_ready_i = 1'($urandom_range(0, 1));
          if (out_ready_i) begin
            if (sb_q.size() == 0) begin
              n_cmp++; n_err++; $display("FAIL rnd_unexpected[%0d]: output with empty scoreboard", t);
            end else begin
              exp = sb_q.pop_front();
              n_cmp++; if (result_o !== exp) begin
                n_err++; $display("FAIL rnd_result[%0d]: a=%h b=%h s=%b got %h need %h", t, a, b, s, result_o, exp);
              end
            end
            done = 1'b1;
          end
        end
        @(posedge clk_i); @(negedge clk_i);
        out_ready_i = 1'b0;
      end
      if (!done) begin
        n_cmp++; n_err++; $display("FAIL rnd_timeout[%0d]: result not delivered in 200 cycles", t);
        sb_q.delete();
      end
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    test_reset();
    rst_ni = 1'b1;
    @(negedge clk_i);
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_latency();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/radix_multiplier.md
Name: radix_multiplier

Overview:
Parametrised iterative integer multiplier with a valid/ready handshake on both sides.
- Retires RADIX_BITS multiplier bits per cycle instead of one.
- Supports signed (two's complement) and unsigned operands, selected per transaction.
- Holds the result under output backpressure.
- Serves as the next-generation area-efficient multiply unit for datapaths where a full array multiplier is too large.

Parameters:
WIDTH, 16, operand width in bits; must be >= 4 and even.
RADIX_BITS, 2, multiplier bits consumed per RUN cycle; legal values 1, 2, 4; must divide WIDTH.

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  asynchronous active-low reset
in_valid_i  input  1  operands valid
in_ready_o  output  1  block can accept operands
a_i  input  WIDTH  multiplicand
b_i  input  WIDTH  multiplier
signed_i  input  1  1 = treat a_i and b_i as two's complement; sampled with the operands
out_valid_o  output  1  result_o valid
out_ready_i  input  1  consumer accepts result
result_o  output  2*WIDTH  product
busy_o  output  1  high whenever state != IDLE

Behaviour:
- Clock and reset: rst_ni is asynchronous, active-low; clk_i is the clock.
- Reset values: in_ready_o=1, out_valid_o=0, result_o=0, busy_o=0, state=IDLE, all internal registers cleared.
- FSM states: IDLE, RUN, OUT (enum state_t).
- IDLE:
  - in_ready_o=1.
  - On in_valid_i && in_ready_o: latch |a|, |b| (WIDTH-bit unsigned magnitudes) and neg = signed_i & (a_msb ^ b_msb); clear acc and digit counter; go to RUN.
  - Unsigned mode: magnitude = operand unchanged.
  - -2^(WIDTH-1) has magnitude 2^(WIDTH-1), which fits unsigned.
- RUN, each cycle:
  - acc += (a_mag * digit) << (cnt*RADIX_BITS), where digit = current low RADIX_BITS of the b shift register.
  - Shift b right by RADIX_BITS; cnt++.
  - All accumulation is 2*WIDTH bits unsigned; no overflow is possible.
- RUN exit:
  - After N = WIDTH/RADIX_BITS RUN cycles, register result_o = neg ? -(final acc) : final acc (2*WIDTH-bit two's complement).
  - Set out_valid_o=1 and go to OUT.
- Latency: operands accepted on edge t; out_valid_o is high from edge t+N+1. For WIDTH=16, RADIX_BITS=2: 9 cycles.
- OUT:
  - result_o and out_valid_o are held stable while out_ready_i=0.
  - On out_ready_i=1: out_valid_o<=0, go to IDLE. in_ready_o rises the cycle after.
  - No new operands are accepted in OUT; no pass-through.
- in_ready_o is asserted only in IDLE. in_valid_i outside IDLE is ignored, with no queuing.
- result_o keeps its last value after the handshake until the next completion.
- Reset mid-operation (RUN or OUT): transaction discarded, all outputs return to reset values, no out_valid_o pulse.
- signed_i=0 with MSB-set operands: treated as large unsigned values.

Optional Feature:
Macro: RADIX_MULTIPLIER_EARLY_TERM_EN
- Defined:
  - RUN exits as soon as the remaining b shift register is all zero, checked at the start of each RUN cycle. This includes b=0, which exits after exactly 1 RUN cycle.
  - Result is identical to full iteration; latency is data-dependent, from 2 to N+1 cycles.
- Undefined: fixed latency N+1 for every transaction.

Decomposition:
- Package radix_multiplier_pkg holds:
  - state_t enum (IDLE, RUN, OUT)
  - localparam N_DIGITS = WIDTH/RADIX_BITS
  - CNT_W = $clog2(N_DIGITS+1)
  - elaboration-time checks on legal WIDTH/RADIX_BITS
- One natural sub-module: radix_pp_gen, a combinational generator of a_mag*digit (WIDTH+RADIX_BITS bits). It is instantiated once and keeps the FSM file free of radix-specific logic.

Test Plan:
- WIDTH=8, RADIX_BITS=2, unsigned: a=255, b=255 -> result_o=0xFE01; out_valid_o first high 5 cycles after accept.
- Signed: a=0x80, b=0x80 -> 0x4000. a=0xFF, b=0x01 -> 0xFFFF. a=0x80, b=0x7F -> 0xC080.
- Backpressure: hold out_ready_i=0 for 10 cycles.
  - result_o (3*7=21) and out_valid_o stay stable; in_ready_o stays 0 and in_valid_i pulses are ignored.
  - Release -> in_ready_o=1 next cycle.
- Reset asserted on the 2nd RUN cycle: out_valid_o never rises, all outputs at reset values. The next transaction 12*10 -> 120 is correct.
- RADIX_BITS in {1,2,4}, 1000 random signed/unsigned pairs each, with random out_ready_i -> result_o matches the reference product.
- With RADIX_MULTIPLIER_EARLY_TERM_EN: b=0 -> result 0, 2-cycle latency. b=0x03, RADIX_BITS=2 -> 2-cycle latency. Without the macro, both take N+1 cycles.
